// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: FSM state type, default parameters and round-robin helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, ACK, RETRY, DONE} arb_state_t;
  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned MAX_RETRY_DEF = 7;
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin picker, first set request at or after rr_ptr_i with wrap
module fifo_arb_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  logic [IW:0] j;
  // scan N positions from the pointer; the first hit wins
  always_comb begin
    valid_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, rr_ptr_i} + (IW+1)'(k);
      j = (j >= (IW+1)'(N)) ? j - (IW+1)'(N) : j;
      if (!valid_o && req_i[j[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port with ack-checked retry; FIFO_WR_ARBITER_SVA_EN enables embedded assertions
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF,
  localparam int unsigned IW = $clog2(NUM_REQ),
  localparam int unsigned RW = $clog2(MAX_RETRY + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          err_drop
);
  arb_state_t state_q;
  logic [IW-1:0] rr_ptr_q, grant_id_q, pick_idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_vec;
  logic [FIFO_WIDTH-1:0] data_q;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic wr_en_q, busy_q, err_drop_q, pick_valid, ack_fail;
  fifo_arb_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i(req),
    .rr_ptr_i(rr_ptr_q),
    .valid_o(pick_valid),
    .idx_o(pick_idx)
  );
  assign gnt_vec = NUM_REQ'(1) << grant_id_q;
  assign retry_cnt_d = retry_cnt_q + RW'(1);
  // overflow marks a lost write even when wr_ack is also seen
  assign ack_fail = !fifo_wr_ack || fifo_overflow;
  // one write in flight: arbitrate in IDLE, write, check the FIFO response, retry or complete
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      gnt_q <= '0;
      wr_en_q <= 1'b0;
      data_q <= '0;
      grant_id_q <= '0;
      busy_q <= 1'b0;
      err_drop_q <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      gnt_q <= '0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_valid && !fifo_full) begin
          grant_id_q <= pick_idx;
          data_q <= req_data[32'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
          wr_en_q <= 1'b1;
          busy_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: state_q <= ACK;
        ACK: if (!ack_fail) begin
          gnt_q <= gnt_vec;
          state_q <= DONE;
        end else begin
          retry_cnt_q <= retry_cnt_d;
          if (retry_cnt_d == RW'(MAX_RETRY)) begin
            err_drop_q <= 1'b1;
            gnt_q <= gnt_vec;
            state_q <= DONE;
          end else begin
            state_q <= RETRY;
          end
        end
        RETRY: if (!fifo_full) begin
          wr_en_q <= 1'b1;
          state_q <= WRITE;
        end
        DONE: begin
          rr_ptr_q <= IW'(rr_next(32'(grant_id_q), NUM_REQ));
          retry_cnt_q <= '0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt = gnt_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_data_in = data_q;
  assign grant_id = grant_id_q;
  assign busy = busy_q;
  assign err_drop = err_drop_q;
`ifdef FIFO_WR_ARBITER_SVA_EN
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_wr_not_full: assert property (@(posedge clk) disable iff (!rst_n) fifo_wr_en |-> !fifo_full);
  a_wr_single: assert property (@(posedge clk) disable iff (!rst_n) fifo_wr_en |=> !fifo_wr_en);
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sva
    a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
      gnt[g] && $past(state_q, 3) == IDLE |-> $past(req[g], 3));
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req[g] && !gnt[g] |=> req[g] && $stable(req_data[g*FIFO_WIDTH +: FIFO_WIDTH]));
  end
  c_idle: cover property (@(posedge clk) state_q == IDLE);
  c_write: cover property (@(posedge clk) state_q == WRITE);
  c_ack: cover property (@(posedge clk) state_q == ACK);
  c_retry: cover property (@(posedge clk) state_q == RETRY);
  c_done: cover property (@(posedge clk) state_q == DONE);
`else
`endif
endmodule
